// File: rtl/buzzer_pkg.sv
// -----------------------------------------------------------------------------
// buzzer_pkg
// Shared types and constants for the buzzer sequencer:
//   - state_t : sequencer FSM states (IDLE / ON / OFF / GAP)
//   - src_t   : active-source codes, numerically ordered by priority
//   - PHASE_W / REP_W : phase (tick) and repeat counter widths
//   - cnt_width() : width of a divide-by-N counter (never below 1 bit)
// -----------------------------------------------------------------------------
package buzzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Code value doubles as priority: a larger code preempts a smaller one.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_KEY  = 2'd1,
    SRC_DONE = 2'd2,
    SRC_ALM  = 2'd3
  } src_t;

  localparam int PHASE_W = 8;
  localparam int REP_W   = 4;

  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/buzzer_tick_gen.sv
// -----------------------------------------------------------------------------
// buzzer_tick_gen
// Restartable pattern-tick prescaler and (optionally) the piezo tone divider.
// Optional feature macro: BUZZER_TONE_EN (tone divider present when defined).
// Ports:
//   i_clk      : system clock
//   i_rst      : synchronous active-high reset
//   i_tick_clr : restart the tick prescaler (phase entry)
//   i_tone_clr : restart the tone divider (ON entry)
//   o_tick     : one-cycle strobe every TICK_DIV cycles since the last restart
//   o_tone     : tone level for the coming cycle (constant 1 without the macro)
// -----------------------------------------------------------------------------
module buzzer_tick_gen
  import buzzer_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int TONE_DIV = 25_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick_clr,
  input  logic i_tone_clr,
  output logic o_tick,
  output logic o_tone
);

  localparam int TICK_W = cnt_width(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] r_tick_cnt;

  assign o_tick = (r_tick_cnt == TICK_LAST);

  // Tick prescaler: restarts on phase entry so each phase is a whole number of ticks
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tick_cnt <= '0;
    end else if (i_tick_clr || o_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

`ifdef BUZZER_TONE_EN
  localparam int TONE_W = cnt_width(TONE_DIV);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

  logic [TONE_W-1:0] r_tone_cnt;
  logic              r_tone_lvl;
  logic              w_tone_wrap;

  assign w_tone_wrap = (r_tone_cnt == TONE_LAST);
  // Next-cycle level, so the caller can register it in step with the FSM:
  // a restart always begins with a high half-period.
  assign o_tone = i_tone_clr ? 1'b1 : (w_tone_wrap ? ~r_tone_lvl : r_tone_lvl);

  // Tone divider: toggles the level every TONE_DIV cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tone_cnt <= '0;
      r_tone_lvl <= 1'b0;
    end else if (i_tone_clr || w_tone_wrap) begin
      r_tone_cnt <= '0;
      r_tone_lvl <= o_tone;
    end else begin
      r_tone_cnt <= r_tone_cnt + TONE_W'(1);
      r_tone_lvl <= o_tone;
    end
  end
`else
  // Active buzzer: steady drive during ON, no divider.
  localparam int TONE_DIV_UNUSED = TONE_DIV;
  logic w_tone_clr_unused;
  assign w_tone_clr_unused = i_tone_clr;
  assign o_tone = 1'b1;
`endif

endmodule

// File: rtl/buzzer_sequencer.sv
// -----------------------------------------------------------------------------
// buzzer_sequencer
// Arbitrating beep-pattern sequencer for the single buzzer output. Latches
// key-click and cycle-done requests, follows the alarm level, grants by fixed
// priority (alarm > done > key) with preemption and plays each source's on/off
// pattern in tick units.
// Optional feature macro: BUZZER_TONE_EN (square-wave tone during ON).
// Ports:
//   i_clk        : 100 MHz system clock
//   i_rst        : synchronous active-high reset
//   i_req_key    : single-cycle key-click request
//   i_req_done   : single-cycle cycle-done request
//   i_alarm      : alarm level, pattern repeats while high
//   o_buzzer     : buzzer drive
//   o_busy       : FSM not in IDLE
//   o_src        : active source (0 none, 1 key, 2 done, 3 alarm)
//   o_done_pulse : one cycle when a finite pattern completes all repeats
// -----------------------------------------------------------------------------
module buzzer_sequencer
  import buzzer_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int TONE_DIV = 25_000,
  parameter int KEY_ON   = 1,
  parameter int KEY_OFF  = 0,
  parameter int KEY_REP  = 1,
  parameter int DONE_ON  = 2,
  parameter int DONE_OFF = 2,
  parameter int DONE_REP = 3,
  parameter int ALM_ON   = 1,
  parameter int ALM_OFF  = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_key,
  input  logic       i_req_done,
  input  logic       i_alarm,
  output logic       o_buzzer,
  output logic       o_busy,
  output logic [1:0] o_src,
  output logic       o_done_pulse
);

  localparam int PH_MAX  = (1 << PHASE_W) - 1;
  localparam int REP_MAX = (1 << REP_W) - 1;

  generate
    if (TICK_DIV < 1 || KEY_ON < 1 || DONE_ON < 1 || ALM_ON < 1 ||
        KEY_ON > PH_MAX || DONE_ON > PH_MAX || ALM_ON > PH_MAX ||
        KEY_OFF < 0 || DONE_OFF < 0 || ALM_OFF < 0 ||
        KEY_OFF > PH_MAX || DONE_OFF > PH_MAX || ALM_OFF > PH_MAX ||
        KEY_REP < 1 || DONE_REP < 1 || KEY_REP > REP_MAX || DONE_REP > REP_MAX) begin : g_param_err
      $error("buzzer_sequencer: pattern parameter outside counter range");
    end
  endgenerate

  function automatic logic [PHASE_W-1:0] on_ticks(input src_t s);
    case (s)
      SRC_KEY:  on_ticks = PHASE_W'(KEY_ON);
      SRC_DONE: on_ticks = PHASE_W'(DONE_ON);
      SRC_ALM:  on_ticks = PHASE_W'(ALM_ON);
      default:  on_ticks = PHASE_W'(1);
    endcase
  endfunction

  function automatic logic [PHASE_W-1:0] off_ticks(input src_t s);
    case (s)
      SRC_KEY:  off_ticks = PHASE_W'(KEY_OFF);
      SRC_DONE: off_ticks = PHASE_W'(DONE_OFF);
      SRC_ALM:  off_ticks = PHASE_W'(ALM_OFF);
      default:  off_ticks = PHASE_W'(0);
    endcase
  endfunction

  // Alarm ignores the repeat counter (it loops while the level is high).
  function automatic logic [REP_W-1:0] rep_count(input src_t s);
    case (s)
      SRC_KEY:  rep_count = REP_W'(KEY_REP);
      SRC_DONE: rep_count = REP_W'(DONE_REP);
      default:  rep_count = REP_W'(1);
    endcase
  endfunction

  state_t               r_state;
  src_t                 r_src;
  logic [PHASE_W-1:0]   r_phase;
  logic [REP_W-1:0]     r_rep;
  logic                 r_pend_key;
  logic                 r_pend_done;
  logic                 r_buzzer;
  logic                 r_busy;
  logic [1:0]           r_src_out;
  logic                 r_done_pulse;

  state_t               w_next_state;
  src_t                 w_next_src;
  src_t                 w_top_src;
  logic [PHASE_W-1:0]   w_next_phase;
  logic [REP_W-1:0]     w_next_rep;
  logic                 w_clear;
  logic                 w_done_evt;
  logic                 w_tick;
  logic                 w_tone;
  logic                 w_expired;
  logic                 w_preempt;
  logic                 w_alarm_lost;

  buzzer_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TONE_DIV (TONE_DIV)
  ) u_tick_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tick_clr (w_clear),
    .i_tone_clr (w_clear && (w_next_state == ST_ON)),
    .o_tick     (w_tick),
    .o_tone     (w_tone)
  );

  // Highest-priority live request: alarm level, then latched done, then key
  always_comb begin
    if (i_alarm) begin
      w_top_src = SRC_ALM;
    end else if (r_pend_done) begin
      w_top_src = SRC_DONE;
    end else if (r_pend_key) begin
      w_top_src = SRC_KEY;
    end else begin
      w_top_src = SRC_NONE;
    end
  end

  assign w_expired    = w_tick && (r_phase <= PHASE_W'(1));
  assign w_preempt    = (w_top_src > r_src);
  assign w_alarm_lost = (r_src == SRC_ALM) && !i_alarm;

  // Next-state logic: phase sequencing, preemption and completion
  always_comb begin
    w_next_state = r_state;
    w_next_src   = r_src;
    w_next_phase = r_phase;
    w_next_rep   = r_rep;
    w_clear      = 1'b0;
    w_done_evt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_top_src != SRC_NONE) begin
          w_next_state = ST_ON;
          w_next_src   = w_top_src;
          w_next_phase = on_ticks(w_top_src);
          w_next_rep   = rep_count(w_top_src);
          w_clear      = 1'b1;
        end else begin
          w_next_src   = SRC_NONE;
        end
      end
      ST_ON, ST_OFF: begin
        if (w_alarm_lost) begin
          // Alarm released: separate with GAP, not a completed pattern.
          w_next_state = ST_GAP;
          w_clear      = 1'b1;
        end else if (w_preempt) begin
          w_next_state = ST_ON;
          w_next_src   = w_top_src;
          w_next_phase = on_ticks(w_top_src);
          w_next_rep   = rep_count(w_top_src);
          w_clear      = 1'b1;
        end else if (w_expired) begin
          if ((r_state == ST_ON) && (off_ticks(r_src) != PHASE_W'(0))) begin
            w_next_state = ST_OFF;
            w_next_phase = off_ticks(r_src);
            w_clear      = 1'b1;
          end else if (r_src == SRC_ALM) begin
            w_next_state = ST_ON;
            w_next_phase = on_ticks(r_src);
            w_clear      = 1'b1;
          end else if (r_rep > REP_W'(1)) begin
            w_next_state = ST_ON;
            w_next_phase = on_ticks(r_src);
            w_next_rep   = r_rep - REP_W'(1);
            w_clear      = 1'b1;
          end else begin
            w_next_state = ST_GAP;
            w_done_evt   = 1'b1;
            w_clear      = 1'b1;
          end
        end else if (w_tick) begin
          w_next_phase = r_phase - PHASE_W'(1);
        end else begin
          w_next_phase = r_phase;
        end
      end
      ST_GAP: begin
        // r_src still names the finished pattern, so only a strictly higher
        // source may cut the gap short.
        if (w_preempt) begin
          w_next_state = ST_ON;
          w_next_src   = w_top_src;
          w_next_phase = on_ticks(w_top_src);
          w_next_rep   = rep_count(w_top_src);
          w_clear      = 1'b1;
        end else if (w_tick) begin
          w_next_state = ST_IDLE;
          w_next_src   = SRC_NONE;
        end else begin
          w_next_state = ST_GAP;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_src   = SRC_NONE;
      end
    endcase
  end

  // State, counters, pending latches and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_src        <= SRC_NONE;
      r_phase      <= '0;
      r_rep        <= '0;
      r_pend_key   <= 1'b0;
      r_pend_done  <= 1'b0;
      r_buzzer     <= 1'b0;
      r_busy       <= 1'b0;
      r_src_out    <= 2'd0;
      r_done_pulse <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_src        <= w_next_src;
      r_phase      <= w_next_phase;
      r_rep        <= w_next_rep;
      // A request landing on the completion cycle wins over the clear.
      r_pend_key   <= i_req_key  | (r_pend_key  & ~(w_done_evt & (r_src == SRC_KEY)));
      r_pend_done  <= i_req_done | (r_pend_done & ~(w_done_evt & (r_src == SRC_DONE)));
      r_buzzer     <= (w_next_state == ST_ON) & w_tone;
      r_busy       <= (w_next_state != ST_IDLE);
      r_src_out    <= ((w_next_state == ST_ON) || (w_next_state == ST_OFF)) ? w_next_src : SRC_NONE;
      r_done_pulse <= w_done_evt;
    end
  end

  assign o_buzzer     = r_buzzer;
  assign o_busy       = r_busy;
  assign o_src        = r_src_out;
  assign o_done_pulse = r_done_pulse;

endmodule
